// File: rtl/sdp_ram_stream_reader.sv
// Read-side controller for the simple dual-port RAM: fetches committed words
// into a 2-entry register buffer and presents them as a valid/ready stream.
module sdp_ram_stream_reader #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_BASE2 = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DEPTH_BASE2:0]   wr_ptr,
  output logic [DEPTH_BASE2-1:0] raddr,
  input  logic [DATA_WIDTH-1:0]  rdata,
  output logic [DEPTH_BASE2:0]   rd_ptr,
  output logic [DEPTH_BASE2:0]   avail,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  output logic                   overflow
);

  localparam int unsigned PW = DEPTH_BASE2 + 1;
  localparam logic [PW-1:0] FULL_CNT = {1'b1, {DEPTH_BASE2{1'b0}}};

  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  pop, fetch;

  assign avail     = wr_ptr - rd_ptr_q;
  assign raddr     = rd_ptr_q[DEPTH_BASE2-1:0];
  assign rd_ptr    = rd_ptr_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_q;
  assign overflow  = overflow_q;

  // Fetch/pop decisions and buffer shifting; flush wins over both.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    head_d      = head_q;
    tail_d      = tail_q;
    pop         = out_valid_q & out_ready;
    fetch       = (avail != '0) & ((occ_q != 2'd2) | pop) & ~flush;
    overflow_d  = overflow_q | (avail > FULL_CNT);

    if (flush) begin
      rd_ptr_d = wr_ptr;
      occ_d    = 2'd0;
    end else begin
      if (fetch) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      occ_d = occ_q + 2'(fetch) - 2'(pop);

      if (pop) begin
        if (occ_q == 2'd2) begin
          head_d = tail_q;
        end else if (fetch) begin
          head_d = rdata;
        end
      end else if (fetch && (occ_q == 2'd0)) begin
        head_d = rdata;
      end

      // New word lands behind the head whenever the head stays occupied.
      if (fetch && ((occ_q == 2'd2) || ((occ_q == 2'd1) && !pop))) begin
        tail_d = rdata;
      end
    end

    out_valid_d = (occ_d != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      occ_q       <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule
